// File: rtl/mem_sdp.sv
// Simple-dual-port RAM with byte-lane writes, 1- or 2-cycle read latency and a zero-fill clear engine.
// Optional sim-only access trace when MEM_SDP_TRACE_EN is defined.
module mem_sdp #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int DEPTH          = 'h1000,
  parameter int READ_LATENCY   = 1,
  parameter int WRITE_FIRST    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  output logic                    ready,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  clr_last, wr_go, rd_go, wr_hit, rd_hit;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  s1_vld;
  logic [DATA_WIDTH-1:0] s1_dat;

  assign clr_last = (clr_addr == LAST_ADDR);
  assign wr_hit   = wr_go && ({1'b0, wr_addr} < DEPTH_W);
  assign rd_hit   = rd_go && ({1'b0, rd_addr} < DEPTH_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      ready <= (CLEAR_ON_RESET == 0);
    end else begin
      state <= state_nxt;
      ready <= (state_nxt == IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clear) state_nxt = CLEAR;
      CLEAR:   if (clr_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_go = 1'b0;
    rd_go = 1'b0;
    if (state == IDLE) begin
      wr_go = wr_en;
      rd_go = rd_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              clr_addr <= '0;
    else if (state == CLEAR) clr_addr <= clr_last ? '0 : clr_addr + 1'b1;
    else if (clear)          clr_addr <= '0;
  end

  // Array is deliberately not reset; the clear engine is the only way to zero it.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_addr[IW-1:0]] <= '0;
    end else if (wr_hit) begin
      for (int i = 0; i < NB; i++)
        if (wr_be[i]) mem[wr_addr[IW-1:0]][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_hit) begin
      rd_word = mem[rd_addr[IW-1:0]];
      if (WRITE_FIRST != 0 && wr_hit && wr_addr == rd_addr)
        for (int i = 0; i < NB; i++)
          if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= rd_go;
      if (rd_go) s1_dat <= rd_word;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_vld;
      logic [DATA_WIDTH-1:0] s2_dat;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_vld <= 1'b0;
          s2_dat <= '0;
        end else begin
          s2_vld <= s1_vld;
          if (s1_vld) s2_dat <= s1_dat;
        end
      end
      assign rd_valid = s2_vld;
      assign rd_data  = s2_dat;
    end else begin : g_lat1
      assign rd_valid = s1_vld;
      assign rd_data  = s1_dat;
    end
  endgenerate

`ifdef MEM_SDP_TRACE_EN
  always @(posedge clk) begin
    if (rst_n) begin
      if (wr_go) $display("%0t mem_sdp wr addr=%h data=%h be=%b", $time, wr_addr, wr_data, wr_be);
      if (rd_go) $display("%0t mem_sdp rd addr=%h data=%h", $time, rd_addr, rd_word);
      if (state == CLEAR && clr_addr == '0) $display("%0t mem_sdp sweep start", $time);
      if (state == CLEAR && clr_last) $display("%0t mem_sdp sweep end", $time);
    end
  end
`endif

endmodule
